curtain_motor_ctrl: RTL and testbench
=====================================

Name: curtain_motor_ctrl

Overview:
- Downstream of the sunlight-delay stage: consumes its registered `Curtain_Open` level as the commanded curtain position.
- Drives a reversible DC motor (forward = open, reverse = close) using two end-limit switches.
- Enforces a dead time before every motor start, a travel timeout, and sensor-fault detection.
- Reports position and fault status to the rest of the controller.

Parameters:
- TMR_W, 16, width of shared dead-time/timeout counter
- DEADTIME, 16'd100, cycles both motor outputs held low before any motor start (min 1)
- TIMEOUT, 16'd50000, max cycles allowed in OPENING/CLOSING before fault (must exceed DEADTIME)
- RETRY_DELAY, 16'd1000, cycles spent in FAULT before auto-retry (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- curtain_open  in  1  commanded position, 1 = open, 0 = closed; level, already synchronous
- limit_open  in  1  fully-open end switch, active-high, already synchronised
- limit_closed  in  1  fully-closed end switch, active-high, already synchronised
- fault_clr  in  1  single-cycle pulse; leaves FAULT
- motor_fwd  out  1  drive open direction
- motor_rev  out  1  drive close direction
- is_open  out  1  curtain confirmed fully open
- busy  out  1  motor moving or pending start
- fault  out  1  latched fault indicator

Behaviour:
- One clock `clk`. Reset is synchronous and active-high on `reset`; all state updates on posedge `clk`.
- All outputs are registered. Reset values: motor_fwd=0, motor_rev=0, is_open=0, busy=0, fault=0, state=INIT, timer=0, target=0.
- States and transitions:
  - INIT: limit_closed → CLOSED; else limit_open → OPEN; else → DEAD with target=close (homing).
  - CLOSED: curtain_open=1 → DEAD, target=open.
  - OPEN: curtain_open=0 → DEAD, target=close.
  - DEAD: motors off; timer counts 0..DEADTIME-1. At DEADTIME-1 → OPENING if target=open, else CLOSING. Timer cleared on every state entry.
  - OPENING: motor_fwd=1. Exit priority, highest first:
    1. limit_open → OPEN.
    2. timer==TIMEOUT-1 → FAULT.
    3. curtain_open=0 → DEAD, target=close (reversal).
  - CLOSING: mirror of OPENING, using motor_rev, limit_closed and curtain_open=1.
  - FAULT: motors off, fault=1. fault_clr → INIT; fault clears on that same edge.
- Any state: limit_open & limit_closed both 1 → FAULT next edge. This overrides all other transitions except reset.
- Motor outputs change on the same edge as the state transition.
  - motor_fwd first rises DEADTIME+1 edges after the first edge sampling curtain_open=1 in CLOSED.
  - motor_fwd and motor_rev are never both 1. On reversal there are always ≥DEADTIME low cycles between the two.
- is_open=1 only in OPEN. busy=1 in INIT, DEAD, OPENING, CLOSING.
- Command toggles during DEAD do not re-target. The new level is evaluated on arrival in OPENING/CLOSING, or in OPEN/CLOSED.
- Limit switch releasing while in OPEN/CLOSED is ignored.
- Reset mid-travel: motors off on the reset edge, state returns to INIT.

Optional Feature:
- Macro: CURTAIN_AUTO_RETRY_EN
- Defined:
  - A FAULT entered by timeout returns to INIT after RETRY_DELAY cycles.
  - At most 2 retries. A 2-bit retry counter increments on each retry and clears on entering OPEN or CLOSED.
  - Exhausted retries, or a both-limits fault, stay latched until fault_clr or reset.
- Undefined:
  - FAULT always latched until fault_clr or reset.
  - RETRY_DELAY unused; no retry counter logic.

Decomposition:
- Package `curtain_pkg`:
  - state enum (INIT, CLOSED, OPEN, DEAD, OPENING, CLOSING, FAULT)
  - target direction typedef
  - default DEADTIME/TIMEOUT/RETRY_DELAY constants
- Sub-module `curtain_tmr`: TMR_W-bit counter with synchronous clear and terminal-count compare. One instance, shared by dead time, timeout and retry delay.

Test Plan:
- Reset with limit_closed=1; raise curtain_open at cycle 10 → motor_fwd rises at edge 111 (DEADTIME=100); assert limit_open 500 cycles later → motor_fwd=0 and is_open=1 on the next edge.
- During OPENING, drop curtain_open → motor_fwd=0 next edge; motor_rev stays 0 for exactly 100 cycles, then rises; motor_fwd & motor_rev never both high.
- OPENING with no limit → fault=1 and motor_fwd=0 exactly TIMEOUT cycles after motor_fwd rose; pulse fault_clr → fault=0, state INIT.
- Raise limit_open and limit_closed together in OPEN → fault=1 next edge, motors off.
- Reset with both limits low → homing: motor_rev rises after 100 cycles; limit_closed → CLOSED, busy=0.
- With CURTAIN_AUTO_RETRY_EN, repeated timeouts → two auto re-attempts each after RETRY_DELAY, third fault latched until fault_clr.

Source files
------------

// File: rtl/curtain_pkg.sv
// Shared types and default timing constants for the curtain motor controller.
// Optional feature macro used by the controller: CURTAIN_AUTO_RETRY_EN.
package curtain_pkg;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_CLOSED  = 3'd1,
      ST_OPEN    = 3'd2,
      ST_DEAD    = 3'd3,
      ST_OPENING = 3'd4,
      ST_CLOSING = 3'd5,
      ST_FAULT   = 3'd6
   } state_t;

   typedef enum logic {
      TGT_CLOSE = 1'b0,
      TGT_OPEN  = 1'b1
   } target_t;

   localparam int          DEF_TMR_W       = 16;
   localparam logic [15:0] DEF_DEADTIME    = 16'd100;
   localparam logic [15:0] DEF_TIMEOUT     = 16'd50000;
   localparam logic [15:0] DEF_RETRY_DELAY = 16'd1000;

   function automatic logic state_is_busy(input state_t s);
      return (s == ST_INIT) || (s == ST_DEAD) || (s == ST_OPENING) || (s == ST_CLOSING);
   endfunction

endpackage

// File: rtl/curtain_motor_ctrl_tmr.sv
// Shared up-counter with synchronous clear and a terminal-count compare
// against a value selected by the owner each cycle.
module curtain_tmr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic [W-1:0] i_tc_val,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/curtain_motor_ctrl.sv
// Reversible curtain motor controller: dead time, travel timeout, limit faults.
// Define CURTAIN_AUTO_RETRY_EN to auto-retry timeout faults (at most twice).
module curtain_motor_ctrl
   import curtain_pkg::*;
#(
   parameter int               TMR_W       = DEF_TMR_W,
   parameter logic [TMR_W-1:0] DEADTIME    = TMR_W'(DEF_DEADTIME),
   parameter logic [TMR_W-1:0] TIMEOUT     = TMR_W'(DEF_TIMEOUT),
   parameter logic [TMR_W-1:0] RETRY_DELAY = TMR_W'(DEF_RETRY_DELAY)
) (
   input  logic clk,
   input  logic reset,
   input  logic curtain_open,
   input  logic limit_open,
   input  logic limit_closed,
   input  logic fault_clr,
   output logic motor_fwd,
   output logic motor_rev,
   output logic is_open,
   output logic busy,
   output logic fault
);

   state_t           r_state;
   state_t           w_state_next;
   target_t          r_target;
   target_t          w_target_next;
   logic             w_tc;
   logic             w_tmr_clr;
   logic [TMR_W-1:0] w_tc_val;
   logic             w_both_limits;
   logic             r_motor_fwd;
   logic             r_motor_rev;
   logic             r_is_open;
   logic             r_busy;
   logic             r_fault;

`ifdef CURTAIN_AUTO_RETRY_EN
   logic [1:0]       r_retry_cnt;
   logic             r_fault_to;
   logic             w_retry_go;
   assign w_retry_go = r_fault_to && (r_retry_cnt != 2'd2) && w_tc;
`endif

   assign w_both_limits = limit_open && limit_closed;

   // One timer serves all timed states; its compare value follows the state.
   always_comb begin
      w_tc_val = TIMEOUT - TMR_W'(1);
      case (r_state)
         ST_DEAD:  w_tc_val = DEADTIME - TMR_W'(1);
         ST_FAULT: w_tc_val = RETRY_DELAY - TMR_W'(1);
         default:  w_tc_val = TIMEOUT - TMR_W'(1);
      endcase
   end

   assign w_tmr_clr = (w_state_next != r_state);

   curtain_tmr #(.W(TMR_W)) u_tmr (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_tmr_clr),
      .i_tc_val (w_tc_val),
      .o_tc     (w_tc)
   );

   always_comb begin
      w_state_next  = r_state;
      w_target_next = r_target;
      case (r_state)
         ST_INIT: begin
            if (limit_closed) begin
               w_state_next = ST_CLOSED;
            end else if (limit_open) begin
               w_state_next = ST_OPEN;
            end else begin
               w_state_next  = ST_DEAD;
               w_target_next = TGT_CLOSE;
            end
         end
         ST_CLOSED: begin
            if (curtain_open) begin
               w_state_next  = ST_DEAD;
               w_target_next = TGT_OPEN;
            end
         end
         ST_OPEN: begin
            if (!curtain_open) begin
               w_state_next  = ST_DEAD;
               w_target_next = TGT_CLOSE;
            end
         end
         ST_DEAD: begin
            if (w_tc) begin
               w_state_next = (r_target == TGT_OPEN) ? ST_OPENING : ST_CLOSING;
            end
         end
         ST_OPENING: begin
            if (limit_open) begin
               w_state_next = ST_OPEN;
            end else if (w_tc) begin
               w_state_next = ST_FAULT;
            end else if (!curtain_open) begin
               w_state_next  = ST_DEAD;
               w_target_next = TGT_CLOSE;
            end
         end
         ST_CLOSING: begin
            if (limit_closed) begin
               w_state_next = ST_CLOSED;
            end else if (w_tc) begin
               w_state_next = ST_FAULT;
            end else if (curtain_open) begin
               w_state_next  = ST_DEAD;
               w_target_next = TGT_OPEN;
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               w_state_next = ST_INIT;
`ifdef CURTAIN_AUTO_RETRY_EN
            end else if (w_retry_go) begin
               w_state_next = ST_INIT;
`endif
            end
         end
         default: w_state_next = ST_INIT;
      endcase
      // Contradictory end switches trump everything but reset.
      if (w_both_limits) begin
         w_state_next = ST_FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_INIT;
         r_target    <= TGT_CLOSE;
         r_motor_fwd <= 1'b0;
         r_motor_rev <= 1'b0;
         r_is_open   <= 1'b0;
         r_busy      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_target    <= w_target_next;
         r_motor_fwd <= (w_state_next == ST_OPENING);
         r_motor_rev <= (w_state_next == ST_CLOSING);
         r_is_open   <= (w_state_next == ST_OPEN);
         r_busy      <= state_is_busy(w_state_next);
         r_fault     <= (w_state_next == ST_FAULT);
      end
   end

`ifdef CURTAIN_AUTO_RETRY_EN
   // Only timeout faults are retryable; a both-limits event makes the fault sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retry_cnt <= 2'd0;
         r_fault_to  <= 1'b0;
      end else begin
         if (w_state_next == ST_FAULT && w_both_limits) begin
            r_fault_to <= 1'b0;
         end else if (w_state_next == ST_FAULT && r_state != ST_FAULT) begin
            r_fault_to <= 1'b1;
         end
         if ((w_state_next == ST_OPEN || w_state_next == ST_CLOSED) && w_state_next != r_state) begin
            r_retry_cnt <= 2'd0;
         end else if (r_state == ST_FAULT && w_state_next == ST_INIT && !fault_clr) begin
            r_retry_cnt <= r_retry_cnt + 2'd1;
         end
      end
   end
`endif

   assign motor_fwd = r_motor_fwd;
   assign motor_rev = r_motor_rev;
   assign is_open   = r_is_open;
   assign busy      = r_busy;
   assign fault     = r_fault;

endmodule

// File: tb/tb_curtain_motor_ctrl.sv
// Self-checking bench for curtain_motor_ctrl; expectations derive from edge counts of the
// behavioural rules (dead time, timeout, retry delay) with randomized travel and toggle times.
module tb_curtain_motor_ctrl;

   localparam logic [15:0] DT = 16'd100;
   localparam logic [15:0] TO = 16'd1500;
   localparam logic [15:0] RD = 16'd200;

   logic clk = 1'b0;
   logic reset, curtain_open, limit_open, limit_closed, fault_clr;
   logic motor_fwd, motor_rev, is_open, busy, fault;

   int   checks   = 0;
   int   failures = 0;
   int   low_cnt  = 0;
   logic prev_fwd = 1'b0;
   logic prev_rev = 1'b0;

   always #5 clk = ~clk;

   curtain_motor_ctrl #(
      .TMR_W       (16),
      .DEADTIME    (DT),
      .TIMEOUT     (TO),
      .RETRY_DELAY (RD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .curtain_open (curtain_open),
      .limit_open   (limit_open),
      .limit_closed (limit_closed),
      .fault_clr    (fault_clr),
      .motor_fwd    (motor_fwd),
      .motor_rev    (motor_rev),
      .is_open      (is_open),
      .busy         (busy),
      .fault        (fault)
   );

   // Advance one edge, sample 1 ns later, and watch the motor safety rules.
   task automatic step();
      @(posedge clk);
      #1;
      checks++;
      if (motor_fwd === 1'b1 && motor_rev === 1'b1) begin
         failures++;
         $display("FAIL both_motors: fwd=%0b rev=%0b, required never both 1", motor_fwd, motor_rev);
      end
      if ((motor_fwd === 1'b1 && !prev_fwd) || (motor_rev === 1'b1 && !prev_rev)) begin
         checks++;
         if (low_cnt < int'(DT)) begin
            failures++;
            $display("FAIL dead_time_before_start: low_cycles=%0d, required>=%0d", low_cnt, DT);
         end
      end
      if (motor_fwd !== 1'b1 && motor_rev !== 1'b1) low_cnt++;
      else low_cnt = 0;
      prev_fwd = (motor_fwd === 1'b1);
      prev_rev = (motor_rev === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1; curtain_open = 1'b0; limit_open = 1'b0; limit_closed = 1'b1; fault_clr = 1'b0;
      repeat (3) step();
      checks++;
      if ({motor_fwd, motor_rev, is_open, busy, fault} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_outputs: got %b, required 00000", {motor_fwd, motor_rev, is_open, busy, fault});
      end
      reset = 1'b0;
      step();
      step();
      checks++;
      if ({motor_fwd, motor_rev, is_open, busy, fault} !== 5'b00000) begin
         failures++;
         $display("FAIL closed_after_reset: got %b, required 00000", {motor_fwd, motor_rev, is_open, busy, fault});
      end
   endtask

   task automatic test_open();
      int n;
      int travel;
      curtain_open = 1'b1;
      step();
      checks++;
      if (busy !== 1'b1 || motor_fwd !== 1'b0) begin
         failures++;
         $display("FAIL dead_entry: busy=%b fwd=%b, required busy=1 fwd=0", busy, motor_fwd);
      end
      n = 1;
      while (motor_fwd !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT) + 1) begin
         failures++;
         $display("FAIL open_start_latency: got %0d edges, required %0d", n, int'(DT) + 1);
      end
      limit_closed = 1'b0;
      travel = int'($urandom_range(5, 600));
      repeat (travel) step();
      checks++;
      if ({motor_fwd, busy, is_open} !== 3'b110) begin
         failures++;
         $display("FAIL opening_midway: fwd/busy/open=%b, required 110", {motor_fwd, busy, is_open});
      end
      limit_open = 1'b1;
      step();
      checks++;
      if ({motor_fwd, is_open, busy} !== 3'b010) begin
         failures++;
         $display("FAIL open_arrival: fwd/open/busy=%b, required 010", {motor_fwd, is_open, busy});
      end
   endtask

   task automatic test_reversal();
      int n;
      curtain_open = 1'b0;
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT) + 1) begin
         failures++;
         $display("FAIL close_start_latency: got %0d edges, required %0d", n, int'(DT) + 1);
      end
      limit_open = 1'b0;
      repeat (int'($urandom_range(3, 300))) step();
      curtain_open = 1'b1;
      step();
      checks++;
      if (motor_rev !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reverse_stop_rev: rev=%b busy=%b, required rev=0 busy=1", motor_rev, busy);
      end
      n = 0;
      while (motor_fwd !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT)) begin
         failures++;
         $display("FAIL reverse_gap_to_fwd: got %0d low edges, required %0d", n, DT);
      end
      repeat (int'($urandom_range(3, 300))) step();
      curtain_open = 1'b0;
      step();
      checks++;
      if (motor_fwd !== 1'b0) begin
         failures++;
         $display("FAIL reverse_stop_fwd: fwd=%b, required 0", motor_fwd);
      end
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT)) begin
         failures++;
         $display("FAIL reverse_gap_to_rev: got %0d low edges, required %0d", n, DT);
      end
      repeat (int'($urandom_range(3, 300))) step();
      limit_closed = 1'b1;
      step();
      checks++;
      if ({motor_rev, busy, is_open} !== 3'b000) begin
         failures++;
         $display("FAIL closed_arrival: rev/busy/open=%b, required 000", {motor_rev, busy, is_open});
      end
   endtask

   task automatic test_dead_toggle();
      int n;
      int k;
      curtain_open = 1'b1;
      step();
      k = int'($urandom_range(1, int'(DT) - 2));
      repeat (k) step();
      curtain_open = 1'b0;
      n = 0;
      while (motor_fwd !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT) - k) begin
         failures++;
         $display("FAIL dead_no_retarget: fwd rose after %0d edges, required %0d", n, int'(DT) - k);
      end
      step();
      checks++;
      if (motor_fwd !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL arrival_reverse: fwd=%b busy=%b, required fwd=0 busy=1", motor_fwd, busy);
      end
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT)) begin
         failures++;
         $display("FAIL arrival_reverse_gap: got %0d edges, required %0d", n, DT);
      end
      step();
      checks++;
      if ({motor_rev, busy} !== 2'b00) begin
         failures++;
         $display("FAIL closing_hits_limit: rev/busy=%b, required 00", {motor_rev, busy});
      end
   endtask

   task automatic test_timeout();
      int n;
      curtain_open = 1'b1;
      n = 0;
      while (motor_fwd !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      limit_closed = 1'b0;
      n = 0;
      while (fault !== 1'b1 && n < int'(TO) + 50) begin step(); n++; end
      checks++;
      if (n != int'(TO)) begin
         failures++;
         $display("FAIL timeout_latency: got %0d edges, required %0d", n, TO);
      end
      checks++;
      if ({motor_fwd, motor_rev, busy} !== 3'b000) begin
         failures++;
         $display("FAIL fault_motors_off: fwd/rev/busy=%b, required 000", {motor_fwd, motor_rev, busy});
      end
`ifndef CURTAIN_AUTO_RETRY_EN
      repeat (int'(RD) + 20) step();
      checks++;
      if (fault !== 1'b1) begin
         failures++;
         $display("FAIL fault_latched: fault=%b, required 1", fault);
      end
`endif
      curtain_open = 1'b0;
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      checks++;
      if ({fault, busy, motor_fwd, motor_rev} !== 4'b0100) begin
         failures++;
         $display("FAIL fault_clear_init: fault/busy/fwd/rev=%b, required 0100", {fault, busy, motor_fwd, motor_rev});
      end
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT) + 1) begin
         failures++;
         $display("FAIL homing_after_clear: got %0d edges, required %0d", n, int'(DT) + 1);
      end
      repeat (int'($urandom_range(3, 200))) step();
      limit_closed = 1'b1;
      step();
      checks++;
      if ({busy, motor_rev} !== 2'b00) begin
         failures++;
         $display("FAIL homing_done: busy/rev=%b, required 00", {busy, motor_rev});
      end
   endtask

   task automatic test_homing_reset();
      int n;
      reset = 1'b1; limit_closed = 1'b0; limit_open = 1'b0; curtain_open = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      checks++;
      if (n != int'(DT) + 1) begin
         failures++;
         $display("FAIL homing_start: got %0d edges, required %0d", n, int'(DT) + 1);
      end
      repeat (int'($urandom_range(3, 200))) step();
      reset = 1'b1;
      step();
      checks++;
      if ({motor_rev, busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_mid_travel: rev/busy=%b, required 00", {motor_rev, busy});
      end
      reset = 1'b0;
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      limit_closed = 1'b1;
      step();
      checks++;
      if ({busy, motor_rev, is_open} !== 3'b000) begin
         failures++;
         $display("FAIL rehome_closed: busy/rev/open=%b, required 000", {busy, motor_rev, is_open});
      end
   endtask

   task automatic test_both_limits();
      int n;
      curtain_open = 1'b1;
      n = 0;
      while (motor_fwd !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      limit_closed = 1'b0;
      repeat (int'($urandom_range(3, 200))) step();
      limit_open = 1'b1;
      step();
      limit_closed = 1'b1;
      step();
      checks++;
      if ({fault, motor_fwd, motor_rev, is_open, busy} !== 5'b10000) begin
         failures++;
         $display("FAIL both_limits_fault: fault/fwd/rev/open/busy=%b, required 10000",
                  {fault, motor_fwd, motor_rev, is_open, busy});
      end
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      checks++;
      if (fault !== 1'b1) begin
         failures++;
         $display("FAIL both_limits_override_clear: fault=%b, required 1", fault);
      end
      limit_closed = 1'b0;
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      step();
      checks++;
      if ({fault, is_open, busy} !== 3'b010) begin
         failures++;
         $display("FAIL recover_open: fault/open/busy=%b, required 010", {fault, is_open, busy});
      end
   endtask

`ifdef CURTAIN_AUTO_RETRY_EN
   task automatic test_auto_retry();
      int n;
      curtain_open = 1'b0;
      n = 0;
      while (motor_rev !== 1'b1 && n < int'(DT) + 50) begin step(); n++; end
      limit_open = 1'b0;
      n = 0;
      while (fault !== 1'b1 && n < int'(TO) + 50) begin step(); n++; end
      checks++;
      if (n != int'(TO)) begin
         failures++;
         $display("FAIL retry_first_timeout: got %0d edges, required %0d", n, TO);
      end
      for (int r = 0; r < 2; r++) begin
         n = 0;
         while (fault === 1'b1 && n < int'(RD) + 50) begin step(); n++; end
         checks++;
         if (n != int'(RD)) begin
            failures++;
            $display("FAIL retry_delay_%0d: got %0d edges, required %0d", r, n, RD);
         end
         n = 0;
         while (fault !== 1'b1 && n < int'(DT) + int'(TO) + 50) begin step(); n++; end
         checks++;
         if (n != 1 + int'(DT) + int'(TO)) begin
            failures++;
            $display("FAIL retry_refault_%0d: got %0d edges, required %0d", r, n, 1 + int'(DT) + int'(TO));
         end
      end
      repeat (int'(RD) + 20) step();
      checks++;
      if (fault !== 1'b1) begin
         failures++;
         $display("FAIL retry_exhausted_latched: fault=%b, required 1", fault);
      end
      limit_closed = 1'b1;
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      step();
      checks++;
      if ({fault, busy} !== 2'b00) begin
         failures++;
         $display("FAIL retry_clear_closed: fault/busy=%b, required 00", {fault, busy});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_open();
      test_reversal();
      test_dead_toggle();
      test_timeout();
      test_homing_reset();
      test_both_limits();
`ifdef CURTAIN_AUTO_RETRY_EN
      test_auto_retry();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
